// File: rtl/mdu_sched.sv
// mdu_sched: iterative multiply/divide unit with IDLE/RUN/FIN scheduling and shortcut completion.
// Optional MDU_FAST_MUL_EN: single-cycle combinational MUL instead of shift-add.
module mdu_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        word,
    input  logic [63:0] srca,
    input  logic [63:0] srcb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t      r_state;
    logic        r_div, r_sel_rem, r_word, r_neg_q, r_neg_r, r_short;
    logic [6:0]  r_cnt;
    logic [63:0] r_q, r_b, r_acc, r_result;

    logic        w_uns, w_sa, w_sb, w_legal, w_bz, w_ovf, w_fast, w_short, w_ge, w_done;
    logic [63:0] w_a, w_b, w_mag_a, w_mag_b, w_fast_res, w_short_res, w_sub;
    logic [63:0] w_qf, w_rf, w_raw, w_fin;
    logic [64:0] w_sh;
    logic [6:0]  w_last;

    assign w_uns   = op[0];
    assign w_a     = word ? (w_uns ? {32'b0, srca[31:0]} : {{32{srca[31]}}, srca[31:0]}) : srca;
    assign w_b     = word ? (w_uns ? {32'b0, srcb[31:0]} : {{32{srcb[31]}}, srcb[31:0]}) : srcb;
    assign w_sa    = ~w_uns & w_a[63];
    assign w_sb    = ~w_uns & w_b[63];
    assign w_mag_a = w_sa ? -w_a : w_a;
    assign w_mag_b = w_sb ? -w_b : w_b;
    assign w_legal = (op == 3'b000) | op[2];
    assign w_bz    = (w_b == 64'd0);
    assign w_ovf   = ~w_uns & (&w_b) &
                     (w_a == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

`ifdef MDU_FAST_MUL_EN
    logic [63:0] w_prod;
    assign w_prod     = w_a * w_b;
    assign w_fast     = (op == 3'b000);
    assign w_fast_res = word ? {{32{w_prod[31]}}, w_prod[31:0]} : w_prod;
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = 64'd0;
`endif

    assign w_short     = ~w_legal | (op[2] & (w_bz | w_ovf)) | w_fast;
    assign w_short_res = ~w_legal ? 64'd0 :
                         ~op[2]   ? w_fast_res :
                         w_bz     ? (op[1] ? (word ? {{32{srca[31]}}, srca[31:0]} : srca) : '1) :
                         (op[1] ? 64'd0 : w_a);

    // Restoring step: shift in the next dividend bit, subtract divisor when it fits.
    assign w_sh   = {r_acc, r_q[63]};
    assign w_ge   = w_sh >= {1'b0, r_b};
    assign w_sub  = w_sh[63:0] - r_b;
    assign w_last = r_word ? 7'd31 : 7'd63;

    assign w_qf   = r_neg_q ? -r_q : r_q;
    assign w_rf   = r_neg_r ? -r_acc : r_acc;
    assign w_raw  = r_div ? (r_sel_rem ? w_rf : w_qf) : r_acc;
    assign w_fin  = r_short ? r_acc : r_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

    // A flush landing on FIN suppresses the pulse and keeps the old result.
    assign w_done = (r_state == FIN) & ~flush & ~reset;
    assign done   = w_done;
    assign busy   = (r_state != IDLE);
    assign result = w_done ? w_fin : r_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 7'd0;
            r_div     <= 1'b0;
            r_sel_rem <= 1'b0;
            r_word    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_short   <= 1'b0;
            r_q       <= 64'd0;
            r_b       <= 64'd0;
            r_acc     <= 64'd0;
            r_result  <= 64'd0;
        end else begin
            case (r_state)
                IDLE: if (start && !flush) begin
                    r_state   <= w_short ? FIN : RUN;
                    r_cnt     <= 7'd0;
                    r_div     <= op[2];
                    r_sel_rem <= op[1];
                    r_word    <= word;
                    r_neg_q   <= w_sa ^ w_sb;
                    r_neg_r   <= w_sa;
                    r_short   <= w_short;
                    r_acc     <= w_short ? w_short_res : 64'd0;
                    r_q       <= ~op[2] ? w_b : word ? {w_mag_a[31:0], 32'b0} : w_mag_a;
                    r_b       <= op[2] ? w_mag_b : w_a;
                end
                RUN: if (flush) begin
                    r_state <= IDLE;
                end else begin
                    r_state <= (r_cnt == w_last) ? FIN : RUN;
                    r_cnt   <= r_cnt + 7'd1;
                    if (r_div) begin
                        r_acc <= w_ge ? w_sub : w_sh[63:0];
                        r_q   <= {r_q[62:0], w_ge};
                    end else begin
                        r_acc <= r_q[0] ? r_acc + r_b : r_acc;
                        r_b   <= {r_b[62:0], 1'b0};
                        r_q   <= {1'b0, r_q[63:1]};
                    end
                end
                default: begin
                    r_state <= IDLE;
                    if (!flush) r_result <= w_fin;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed self-checking bench for mdu_sched.
module tb_mdu_sched;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, word = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [63:0] srca = 64'd0, srcb = 64'd0;
    logic        busy, done;
    logic [63:0] result;
    int          n_tests = 0, n_fail = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int ML64 = 1, ML32 = 1;
`else
    localparam int ML64 = 65, ML32 = 33;
`endif

    mdu_sched dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .word(word),
        .srca(srca), .srcb(srcb), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input int lat, input logic [63:0] res);
        int c, nb;
        op = o; word = w; srca = a; srcb = b; start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        nb = int'(busy);
        while (!done && c < 200) begin
            tick;
            c++;
            nb += int'(busy);
        end
        check({tag, " lat"}, 64'(c), 64'(lat));
        check({tag, " res"}, result, res);
        check({tag, " busy"}, 64'(nb), 64'(lat));
        tick;
        check({tag, " idle"}, {63'd0, busy}, 64'd0);
        check({tag, " hold"}, result, res);
    endtask

    initial begin
        int nd, dc;
        logic [63:0] rr;
        tick; tick;
        reset = 1'b0;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst result", result, 64'd0);

        run("mul",      3'b000, 1'b0, 64'd7, -64'sd3, ML64, 64'hFFFF_FFFF_FFFF_FFEB);
        run("mulw",     3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, ML32, 64'hFFFF_FFFF_FFFF_FFFE);
        run("divw",     3'b100, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run("remw",     3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run("div neg",  3'b100, 1'b0, -64'sd100, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2);
        run("rem neg",  3'b110, 1'b0, -64'sd100, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFFE);
        run("divu big", 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 65, 64'h5555_5555_5555_5555);
        run("divuw",    3'b101, 1'b1, 64'hFFFF_FFFF, 64'd2, 33, 64'h0000_0000_7FFF_FFFF);
        run("remuw",    3'b111, 1'b1, 64'hFFFF_FFFF, 64'd10, 33, 64'd5);
        run("divu z",   3'b101, 1'b0, 64'd100, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remu z",   3'b111, 1'b0, 64'd100, 64'd0, 1, 64'd100);
        run("divw z",   3'b100, 1'b1, 64'd5, 64'h1_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run("div ovf",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000);
        run("rem ovf",  3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'd0);
        run("illegal",  3'b001, 1'b0, 64'd9, 64'd3, 1, 64'd0);
        run("divu",     3'b101, 1'b0, 64'd1000, 64'd10, 65, 64'd100);

        // flush mid-RUN at cycle 20
        op = 3'b101; word = 1'b0; srca = 64'd1000; srcb = 64'd10; srcb = 64'd7; start = 1'b1;
        tick;
        start = 1'b0;
        nd = int'(done);
        repeat (19) begin tick; nd += int'(done); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        check("flush nodone", 64'(nd), 64'd0);
        check("flush result", result, 64'd100);
        run("flush restart", 3'b101, 1'b0, 64'd1000, 64'd10, 65, 64'd100);

        // flush landing on FIN
        op = 3'b101; srca = 64'd8; srcb = 64'd2; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (64) tick;
        check("fin pre done", {63'd0, done}, 64'd1);
        flush = 1'b1;
        #1;
        check("fin flush done", {63'd0, done}, 64'd0);
        check("fin flush res", result, 64'd100);
        tick;
        flush = 1'b0;
        check("fin flush idle", {63'd0, busy}, 64'd0);
        check("fin flush hold", result, 64'd100);

        // flush and start together in IDLE
        op = 3'b101; srca = 64'd50; srcb = 64'd5; start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {63'd0, busy}, 64'd0);
        tick;
        check("flush+start done", {63'd0, done}, 64'd0);

        // start held high throughout
        op = 3'b101; srca = 64'd1000; srcb = 64'd7; start = 1'b1;
        nd = 0; dc = 0; rr = 64'd0;
        for (int k = 1; k <= 66; k++) begin
            tick;
            if (done) begin nd++; dc = k; rr = result; end
        end
        check("held ndone", 64'(nd), 64'd1);
        check("held lat", 64'(dc), 64'd65);
        check("held res", rr, 64'd142);
        check("held idle", {63'd0, busy}, 64'd0);
        tick;
        check("held reaccept", {63'd0, busy}, 64'd1);
        repeat (9) tick;
        reset = 1'b1; flush = 1'b1;
        tick;
        check("mid rst busy", {63'd0, busy}, 64'd0);
        check("mid rst done", {63'd0, done}, 64'd0);
        check("mid rst result", result, 64'd0);
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        tick;
        check("post rst busy", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
